// File: rtl/timer_irq_pkg.sv
// Shared constants for the timer interrupt stage: register offsets
// (address bits [3:2]) and the bit positions inside ENABLE and STATUS.
package timer_irq_pkg;

  // Register select values taken from address bits [3:2]
  localparam logic [1:0] TIMER_IRQ_MSIP     = 2'b00;
  localparam logic [1:0] TIMER_IRQ_ENABLE   = 2'b01;
  localparam logic [1:0] TIMER_IRQ_STATUS   = 2'b10;
  localparam logic [1:0] TIMER_IRQ_RESERVED = 2'b11;

  // ENABLE register bit positions
  localparam int ENABLE_MTIE_BIT = 0;
  localparam int ENABLE_MSIE_BIT = 1;

  // STATUS register bit positions
  localparam int STATUS_MTIP_BIT = 0;
  localparam int STATUS_MSIP_BIT = 1;

endpackage

// File: rtl/timer_irq_if.sv
// Memory-bus slave port of the timer interrupt stage. The master drives
// address, select, strobes and write data; the slave returns read data.
interface timer_irq_if;

  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;

  modport master (
    output address_in,
    output sel_in,
    output read_in,
    input  read_value_out,
    output write_mask_in,
    output write_value_in
  );

  modport slave (
    input  address_in,
    input  sel_in,
    input  read_in,
    output read_value_out,
    input  write_mask_in,
    input  write_value_in
  );

endinterface

// File: rtl/timer_irq_cmp64_pipe.sv
// Two-stage unsigned 64-bit "a >= b" comparator. Stage 1 splits the compare
// into upper/lower 32-bit halves; stage 2 combines them. A flush drops the
// result immediately and marks the next stage-1 slot invalid, so nothing
// computed against stale operands can reach the output.
module cmp64_pipe (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_in,
  input  logic [63:0] a_in,
  input  logic [63:0] b_in,
  output logic        ge_valid_out
);

  logic valid1_reg;
  logic hi_gt_reg;
  logic hi_eq_reg;
  logic lo_ge_reg;
  logic ge_reg;

  // Split-half compare registered in stage 1, combined into the result in stage 2
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid1_reg <= 1'b0;
      hi_gt_reg  <= 1'b0;
      hi_eq_reg  <= 1'b0;
      lo_ge_reg  <= 1'b0;
      ge_reg     <= 1'b0;
    end else begin
      valid1_reg <= ~flush_in;
      hi_gt_reg  <= a_in[63:32] >  b_in[63:32];
      hi_eq_reg  <= a_in[63:32] == b_in[63:32];
      lo_ge_reg  <= a_in[31:0]  >= b_in[31:0];
      if (flush_in) begin
        ge_reg <= 1'b0;
      end else begin
        ge_reg <= valid1_reg & (hi_gt_reg | (hi_eq_reg & lo_ge_reg));
      end
    end
  end

  assign ge_valid_out = ge_reg;

endmodule

// File: rtl/timer_irq.sv
// Machine timer / software interrupt stage. Compares mtime against mtimecmp
// through a two-stage pipeline to form the timer-pending bit, and holds the
// MSIP and ENABLE registers on the shared memory bus. Interrupt lines are
// plain ANDs of registered bits, so they never glitch within a clock.
module timer_irq
  import timer_irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] cycle_in,
  input  logic [63:0] mtimecmp_in,
  input  logic        mtimecmp_write_in,
  timer_irq_if.slave  bus,
  output logic        timer_irq_out,
  output logic        soft_irq_out
);

  logic        msip_reg;
  logic        mtie_reg;
  logic        msie_reg;
  logic        msip_next;
  logic        mtie_next;
  logic        msie_next;
  logic        mtip;
  logic        wr_en;
  logic [31:0] read_value;

  // Only byte 0 carries register bits, so only mask bit 0 qualifies a write
  assign wr_en = bus.sel_in & bus.write_mask_in[0];

  cmp64_pipe u_cmp (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush_in     (mtimecmp_write_in),
    .a_in         (cycle_in),
    .b_in         (mtimecmp_in),
    .ge_valid_out (mtip)
  );

  // Next-state of the writable register bits; reserved and STATUS writes are dropped
  always_comb begin
    msip_next = msip_reg;
    mtie_next = mtie_reg;
    msie_next = msie_reg;
    if (wr_en) begin
      case (bus.address_in[3:2])
        TIMER_IRQ_MSIP: begin
          msip_next = bus.write_value_in[0];
        end
        TIMER_IRQ_ENABLE: begin
          mtie_next = bus.write_value_in[ENABLE_MTIE_BIT];
          msie_next = bus.write_value_in[ENABLE_MSIE_BIT];
        end
        default: begin
        end
      endcase
    end
  end

  // Register file update; reset wins over any concurrent bus write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      msip_reg <= 1'b0;
      mtie_reg <= 1'b0;
      msie_reg <= 1'b0;
    end else begin
      msip_reg <= msip_next;
      mtie_reg <= mtie_next;
      msie_reg <= msie_next;
    end
  end

  // Combinational read mux; returns pre-write contents during a write cycle
  always_comb begin
    read_value = '0;
    if (bus.sel_in) begin
      case (bus.address_in[3:2])
        TIMER_IRQ_MSIP: begin
          read_value[0] = msip_reg;
        end
        TIMER_IRQ_ENABLE: begin
          read_value[ENABLE_MTIE_BIT] = mtie_reg;
          read_value[ENABLE_MSIE_BIT] = msie_reg;
        end
        TIMER_IRQ_STATUS: begin
          read_value[STATUS_MTIP_BIT] = mtip;
          read_value[STATUS_MSIP_BIT] = msip_reg;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.read_value_out = read_value;

  assign timer_irq_out = mtip & mtie_reg;
  assign soft_irq_out  = msip_reg & msie_reg;

  // Bus fields that carry no meaning for this block
  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, bus.read_in, bus.address_in[31:4],
                             bus.address_in[1:0], bus.write_mask_in[3:1],
                             bus.write_value_in[31:2]};

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: compare pipeline latency, half-word carry,
// mtimecmp-write invalidation, register file behaviour, wrap-around, reset.
module tb_timer_irq;
  import timer_irq_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [63:0] cycle_in;
  logic [63:0] mtimecmp_in;
  logic        mtimecmp_write_in;
  logic        timer_irq_out;
  logic        soft_irq_out;

  int vectors;
  int miscompares;

  timer_irq_if bus ();

  timer_irq dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cycle_in          (cycle_in),
    .mtimecmp_in       (mtimecmp_in),
    .mtimecmp_write_in (mtimecmp_write_in),
    .bus               (bus),
    .timer_irq_out     (timer_irq_out),
    .soft_irq_out      (soft_irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] A_MSIP   = 32'h0000_0000;
  localparam logic [31:0] A_ENABLE = 32'h0000_0004;
  localparam logic [31:0] A_STATUS = 32'h0000_0008;
  localparam logic [31:0] A_RSVD   = 32'h0000_000C;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=0x%0h expected=0x%0h", vectors, tag, obs, exp);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    bus.sel_in         = 1'b1;
    bus.address_in     = addr;
    bus.write_mask_in  = mask;
    bus.write_value_in = data;
    tick();
    bus.sel_in         = 1'b0;
    bus.write_mask_in  = 4'h0;
    bus.write_value_in = 32'h0;
    bus.address_in     = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.sel_in     = 1'b1;
    bus.address_in = addr;
    #1;
    data = bus.read_value_out;
    bus.sel_in     = 1'b0;
    bus.address_in = 32'h0;
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    vectors     = 0;
    miscompares = 0;

    reset_n            = 1'b0;
    cycle_in           = 64'd0;
    mtimecmp_in        = 64'd0;
    mtimecmp_write_in  = 1'b0;
    bus.sel_in         = 1'b0;
    bus.read_in        = 1'b0;
    bus.address_in     = 32'h0;
    bus.write_mask_in  = 4'h0;
    bus.write_value_in = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_timer_irq", {63'd0, timer_irq_out}, 64'd0);
    chk("rst_soft_irq", {63'd0, soft_irq_out}, 64'd0);
    chk("rst_rdata_unsel", {32'd0, bus.read_value_out}, 64'd0);
    reset_n = 1'b1;
    bus_read(A_ENABLE, rd);
    chk("rst_enable_read", {32'd0, rd}, 64'd0);

    // Count up to mtimecmp=100; pending appears two edges after cycle_in=100
    mtimecmp_in = 64'd100;
    cycle_in    = 64'd90;
    bus_write(A_ENABLE, 4'h1, 32'h1);
    for (int c = 90; c <= 101; c++) begin
      cycle_in = 64'(c);
      tick();
      chk($sformatf("count_irq_c%0d", c), {63'd0, timer_irq_out}, (c >= 101) ? 64'd1 : 64'd0);
    end
    bus_read(A_STATUS, rd);
    chk("count_status", {32'd0, rd}, 64'h1);

    // Carry across the 32-bit halves
    mtimecmp_in = 64'h1_0000_0000;
    cycle_in    = 64'h0_FFFF_FFFF;
    tick();
    tick();
    chk("carry_below", {63'd0, timer_irq_out}, 64'd0);
    cycle_in = 64'h1_0000_0000;
    tick();
    chk("carry_lat1", {63'd0, timer_irq_out}, 64'd0);
    tick();
    chk("carry_equal", {63'd0, timer_irq_out}, 64'd1);

    // mtimecmp write clears a stale pending at once
    mtimecmp_in       = 64'hFFFF_FFFF_FFFF_FFFF;
    mtimecmp_write_in = 1'b1;
    tick();
    chk("inval_edge", {63'd0, timer_irq_out}, 64'd0);
    mtimecmp_write_in = 1'b0;
    tick();
    chk("inval_plus1", {63'd0, timer_irq_out}, 64'd0);
    tick();
    chk("inval_plus2", {63'd0, timer_irq_out}, 64'd0);
    tick();
    chk("inval_plus3", {63'd0, timer_irq_out}, 64'd0);

    // Back-to-back mtimecmp writes hold pending low until two edges after the last
    mtimecmp_in = 64'd100;
    cycle_in    = 64'd200;
    tick();
    tick();
    chk("b2b_setup", {63'd0, timer_irq_out}, 64'd1);
    mtimecmp_write_in = 1'b1;
    tick();
    chk("b2b_w1", {63'd0, timer_irq_out}, 64'd0);
    tick();
    chk("b2b_w2", {63'd0, timer_irq_out}, 64'd0);
    mtimecmp_write_in = 1'b0;
    tick();
    chk("b2b_plus1", {63'd0, timer_irq_out}, 64'd0);
    tick();
    chk("b2b_plus2", {63'd0, timer_irq_out}, 64'd1);

    // Software interrupt and enable gating
    bus_write(A_ENABLE, 4'h1, 32'h0);
    chk("dis_timer_irq", {63'd0, timer_irq_out}, 64'd0);
    bus_write(A_MSIP, 4'h1, 32'h1);
    chk("msip_soft_masked", {63'd0, soft_irq_out}, 64'd0);
    bus_read(A_STATUS, rd);
    chk("msip_status", {32'd0, rd}, 64'h3);
    bus_write(A_ENABLE, 4'h1, 32'h2);
    chk("msie_soft_irq", {63'd0, soft_irq_out}, 64'd1);
    chk("msie_timer_off", {63'd0, timer_irq_out}, 64'd0);
    // Read during a write returns the old value
    bus.sel_in         = 1'b1;
    bus.address_in     = A_ENABLE;
    bus.write_mask_in  = 4'h1;
    bus.write_value_in = 32'h3;
    #1;
    chk("rd_during_wr", {32'd0, bus.read_value_out}, 64'h2);
    tick();
    bus.sel_in = 1'b0;
    bus.write_mask_in = 4'h0;
    chk("mtie_on_pending", {63'd0, timer_irq_out}, 64'd1);
    bus_write(A_MSIP, 4'hE, 32'h0);
    chk("mask_hi_ignored", {63'd0, soft_irq_out}, 64'd1);
    bus_write(A_MSIP, 4'hF, 32'hFFFF_FFFF);
    bus_read(A_MSIP, rd);
    chk("msip_upper_zero", {32'd0, rd}, 64'h1);
    bus_write(A_RSVD, 4'hF, 32'hFFFF_FFFF);
    bus_read(A_RSVD, rd);
    chk("rsvd_read", {32'd0, rd}, 64'h0);
    bus_read(A_ENABLE, rd);
    chk("enable_read", {32'd0, rd}, 64'h3);
    chk("unsel_rdata", {32'd0, bus.read_value_out}, 64'h0);

    // Wrap-around of mtime drops the pending two edges later
    mtimecmp_in = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle_in    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    chk("wrap_max", {63'd0, timer_irq_out}, 64'd1);
    cycle_in = 64'd0;
    tick();
    chk("wrap_lat1", {63'd0, timer_irq_out}, 64'd1);
    tick();
    chk("wrap_low", {63'd0, timer_irq_out}, 64'd0);

    // Reset with pending irq and a concurrent bus write / mtimecmp write
    mtimecmp_in = 64'd0;
    cycle_in    = 64'd5;
    tick();
    tick();
    chk("pre_rst_timer", {63'd0, timer_irq_out}, 64'd1);
    chk("pre_rst_soft", {63'd0, soft_irq_out}, 64'd1);
    reset_n            = 1'b0;
    mtimecmp_write_in  = 1'b1;
    bus.sel_in         = 1'b1;
    bus.address_in     = A_ENABLE;
    bus.write_mask_in  = 4'h1;
    bus.write_value_in = 32'h3;
    tick();
    bus.sel_in         = 1'b0;
    bus.write_mask_in  = 4'h0;
    bus.write_value_in = 32'h0;
    mtimecmp_write_in  = 1'b0;
    chk("rst_mid_timer", {63'd0, timer_irq_out}, 64'd0);
    chk("rst_mid_soft", {63'd0, soft_irq_out}, 64'd0);
    reset_n = 1'b1;
    tick();
    bus_read(A_ENABLE, rd);
    chk("post_rst_enable", {32'd0, rd}, 64'h0);
    bus_read(A_MSIP, rd);
    chk("post_rst_msip", {32'd0, rd}, 64'h0);
    bus_read(A_STATUS, rd);
    chk("post_rst_status", {32'd0, rd}, 64'h0);
    bus_write(A_ENABLE, 4'h1, 32'h1);
    chk("post_rst_fresh", {63'd0, timer_irq_out}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
